// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer constants and entry type, also used by the issue queue and the
// writeback bus.
package reorder_buffer_pkg;

  localparam int unsigned ROB_SIZE_LOG2 = 4;
  localparam int unsigned ROB_SIZE      = 1 << ROB_SIZE_LOG2;
  localparam int unsigned NUM_REG_LOG2  = 5;
  localparam int unsigned REG_SIZE      = 32;
  localparam int unsigned TAG_W         = NUM_REG_LOG2 + 1;

  typedef logic [TAG_W-1:0]         preg_t;
  typedef logic [ROB_SIZE_LOG2-1:0] rob_idx_t;
  typedef logic [ROB_SIZE_LOG2:0]   rob_cnt_t;
  typedef logic [REG_SIZE-1:0]      reg_data_t;

  typedef struct packed {
    logic      valid;
    logic      done;
    preg_t     prd;
    preg_t     old_prd;
    reg_data_t data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order completion tracker: allocates at the tail, marks entries done on writeback and
// retires the head entry in program order, at most one per cycle.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      alloc_valid,
  input  preg_t     alloc_prd,
  input  preg_t     alloc_old_prd,
  output logic      alloc_ready,
  output rob_idx_t  rob_index,
  input  logic      wb_valid,
  input  rob_idx_t  wb_index,
  input  reg_data_t wb_data,
  output logic      commit_valid,
  output preg_t     commit_prd,
  output preg_t     commit_old_prd,
  output reg_data_t commit_data,
  input  logic      flush,
  output logic      empty
);

  rob_entry_t entries_q [ROB_SIZE];
  rob_idx_t   head_q;
  rob_idx_t   tail_q;
  rob_cnt_t   count_q;

  logic       full;
  logic       alloc_fire;
  rob_entry_t head_entry;

  always_comb begin
    full           = (count_q == rob_cnt_t'(ROB_SIZE));
    alloc_ready    = !full && !flush;
    alloc_fire     = alloc_valid && alloc_ready;
    rob_index      = tail_q;
    empty          = (count_q == '0);
    head_entry     = entries_q[head_q];
    commit_valid   = head_entry.valid && head_entry.done && !flush;
    commit_prd     = '0;
    commit_old_prd = '0;
    commit_data    = '0;
    if (commit_valid) begin
      commit_prd     = head_entry.prd;
      commit_old_prd = head_entry.old_prd;
      commit_data    = head_entry.data;
    end
  end

  // Alloc is written last so it wins over a same-index writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROB_SIZE; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < ROB_SIZE; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (commit_valid) begin
        entries_q[head_q].valid <= 1'b0;
        head_q                  <= head_q + 1'b1;
      end
      if (wb_valid && entries_q[wb_index].valid) begin
        entries_q[wb_index].done <= 1'b1;
        entries_q[wb_index].data <= wb_data;
      end
      if (alloc_fire) begin
        entries_q[tail_q] <= '{valid: 1'b1, done: 1'b0, prd: alloc_prd,
                               old_prd: alloc_old_prd, data: '0};
        tail_q            <= tail_q + 1'b1;
      end
      count_q <= count_q + rob_cnt_t'(alloc_fire) - rob_cnt_t'(commit_valid);
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected retirements are queued at alloc, filled in at
// writeback and popped when the DUT commits.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  logic      alloc_valid = 1'b0;
  preg_t     alloc_prd = '0;
  preg_t     alloc_old_prd = '0;
  logic      alloc_ready;
  rob_idx_t  rob_index;
  logic      wb_valid = 1'b0;
  rob_idx_t  wb_index = '0;
  reg_data_t wb_data = '0;
  logic      commit_valid;
  preg_t     commit_prd;
  preg_t     commit_old_prd;
  reg_data_t commit_data;
  logic      flush = 1'b0;
  logic      empty;

  reorder_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid    (alloc_valid),
    .alloc_prd      (alloc_prd),
    .alloc_old_prd  (alloc_old_prd),
    .alloc_ready    (alloc_ready),
    .rob_index      (rob_index),
    .wb_valid       (wb_valid),
    .wb_index       (wb_index),
    .wb_data        (wb_data),
    .commit_valid   (commit_valid),
    .commit_prd     (commit_prd),
    .commit_old_prd (commit_old_prd),
    .commit_data    (commit_data),
    .flush          (flush),
    .empty          (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    rob_idx_t  idx;
    preg_t     prd;
    preg_t     old_prd;
    reg_data_t data;
  } exp_t;

  exp_t     sb[$];
  exp_t     e;
  exp_t     e_none = '{idx: '0, prd: '0, old_prd: '0, data: '0};
  rob_idx_t m_tail;
  int       checks = 0;
  int       failures = 0;

  function automatic void sb_push(rob_idx_t idx, preg_t p, preg_t o);
    sb.push_back('{idx: idx, prd: p, old_prd: o, data: '0});
  endfunction

  function automatic void sb_wb(rob_idx_t idx, reg_data_t d);
    foreach (sb[i]) if (sb[i].idx == idx) sb[i].data = d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0;
    wb_valid    = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    sb.delete();
    m_tail = '0;
  endtask

  // Drains a full buffer whose head sits at m_tail: one in-order wb per cycle, each retiring
  // the following cycle.
  task automatic drain_full(string name);
    for (int c = 0; c <= ROB_SIZE; c++) begin
      if (c < ROB_SIZE) begin
        wb_valid = 1'b1;
        wb_index = rob_idx_t'(m_tail + c);
        wb_data  = $urandom;
        sb_wb(wb_index, wb_data);
      end else begin
        wb_valid = 1'b0;
      end
      #1;
      checks++;
      if (commit_valid !== (c > 0)) begin
        failures++;
        $display("FAIL %s_valid c=%0d got=%b exp=%b", name, c, commit_valid, c > 0);
      end
      if (c > 0) begin
        e = (sb.size() != 0) ? sb.pop_front() : e_none;
        checks++;
        if ({commit_prd, commit_old_prd, commit_data} !== {e.prd, e.old_prd, e.data}) begin
          failures++;
          $display("FAIL %s_payload c=%0d got=%h/%h/%h exp=%h/%h/%h", name, c, commit_prd,
                   commit_old_prd, commit_data, e.prd, e.old_prd, e.data);
        end
      end
      tick();
    end
    wb_valid = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL %s_empty got=%b exp=1", name, empty);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({empty, alloc_ready, rob_index, commit_valid} !== {1'b1, 1'b1, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_init got=%b/%b/%0d/%b exp=1/1/0/0", empty, alloc_ready, rob_index,
               commit_valid);
    end
    for (int i = 0; i < 3; i++) begin
      alloc_valid   = 1'b1;
      alloc_prd     = preg_t'(i + 1);
      alloc_old_prd = preg_t'(i + 20);
      tick();
    end
    alloc_valid = 1'b0;
    wb_valid    = 1'b1;
    wb_index    = 4'd0;
    wb_data     = 32'h1234;
    tick();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (commit_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_commit got=%b exp=1", commit_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({empty, alloc_ready, rob_index, commit_valid, commit_prd} !==
        {1'b1, 1'b1, 4'd0, 1'b0, 6'd0}) begin
      failures++;
      $display("FAIL reset_async got=%b/%b/%0d/%b/%0d exp=1/1/0/0/0", empty, alloc_ready,
               rob_index, commit_valid, commit_prd);
    end
    tick();
    tick();
    rst = 1'b1;
    sb.delete();
    m_tail = '0;
    tick();
    checks++;
    if ({empty, alloc_ready, rob_index, commit_valid} !== {1'b1, 1'b1, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_release got=%b/%b/%0d/%b exp=1/1/0/0", empty, alloc_ready, rob_index,
               commit_valid);
    end
  endtask

  task automatic test_in_order();
    for (int i = 0; i < 3; i++) begin
      alloc_valid   = 1'b1;
      alloc_prd     = preg_t'(3 + i);
      alloc_old_prd = preg_t'(10 + i);
      #1;
      checks++;
      if (rob_index !== m_tail) begin
        failures++;
        $display("FAIL inorder_index got=%0d exp=%0d", rob_index, m_tail);
      end
      sb_push(m_tail, alloc_prd, alloc_old_prd);
      tick();
      m_tail++;
    end
    alloc_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1'b1;
      wb_index = rob_idx_t'(2 - k);
      wb_data  = 32'hA0 + k;
      sb_wb(wb_index, wb_data);
      #1;
      checks++;
      if (commit_valid !== 1'b0) begin
        failures++;
        $display("FAIL inorder_wait k=%0d got=%b exp=0", k, commit_valid);
      end
      tick();
    end
    wb_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      e = (sb.size() != 0) ? sb.pop_front() : e_none;
      checks++;
      if ({commit_valid, commit_prd, commit_old_prd, commit_data} !==
          {1'b1, e.prd, e.old_prd, e.data}) begin
        failures++;
        $display("FAIL inorder_commit k=%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", k, commit_valid,
                 commit_prd, commit_old_prd, commit_data, e.prd, e.old_prd, e.data);
      end
      tick();
    end
    checks++;
    if ({commit_valid, empty} !== 2'b01) begin
      failures++;
      $display("FAIL inorder_done got=%b/%b exp=0/1", commit_valid, empty);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < ROB_SIZE; i++) begin
      alloc_valid   = 1'b1;
      alloc_prd     = preg_t'(i);
      alloc_old_prd = preg_t'(i + 32);
      #1;
      checks++;
      if ({alloc_ready, rob_index} !== {1'b1, m_tail}) begin
        failures++;
        $display("FAIL full_fill i=%0d got=%b/%0d exp=1/%0d", i, alloc_ready, rob_index, m_tail);
      end
      sb_push(m_tail, alloc_prd, alloc_old_prd);
      tick();
      m_tail++;
    end
    alloc_prd     = 6'd50;
    alloc_old_prd = 6'd51;
    wb_valid      = 1'b1;
    wb_index      = 4'd0;
    wb_data       = 32'hF00D;
    sb_wb(4'd0, wb_data);
    #1;
    checks++;
    if ({alloc_ready, commit_valid} !== 2'b00) begin
      failures++;
      $display("FAIL full_blocked got=%b/%b exp=0/0", alloc_ready, commit_valid);
    end
    tick();
    wb_valid = 1'b0;
    #1;
    e = (sb.size() != 0) ? sb.pop_front() : e_none;
    checks++;
    if ({alloc_ready, commit_valid, commit_prd, commit_data} !== {2'b01, e.prd, e.data}) begin
      failures++;
      $display("FAIL full_retire got=%b/%b/%h/%h exp=0/1/%h/%h", alloc_ready, commit_valid,
               commit_prd, commit_data, e.prd, e.data);
    end
    tick();
    checks++;
    if ({alloc_ready, rob_index} !== {1'b1, 4'd0}) begin
      failures++;
      $display("FAIL full_wrap_alloc got=%b/%0d exp=1/0", alloc_ready, rob_index);
    end
    sb_push(m_tail, alloc_prd, alloc_old_prd);
    tick();
    m_tail++;
    alloc_valid = 1'b0;
    drain_full("full_drain");
  endtask

  task automatic test_wrap();
    rob_idx_t last_idx = m_tail;
    for (int c = 0; c < 42; c++) begin
      alloc_valid   = (c < 40);
      alloc_prd     = preg_t'($urandom);
      alloc_old_prd = preg_t'($urandom);
      wb_valid      = (c >= 1 && c <= 40);
      wb_index      = last_idx;
      wb_data       = $urandom;
      #1;
      if (wb_valid) sb_wb(wb_index, wb_data);
      if (alloc_valid) begin
        checks++;
        if (rob_index !== m_tail) begin
          failures++;
          $display("FAIL wrap_index c=%0d got=%0d exp=%0d", c, rob_index, m_tail);
        end
        sb_push(m_tail, alloc_prd, alloc_old_prd);
      end
      checks++;
      if (commit_valid !== (c >= 2)) begin
        failures++;
        $display("FAIL wrap_valid c=%0d got=%b exp=%b", c, commit_valid, c >= 2);
      end
      if (c >= 2) begin
        e = (sb.size() != 0) ? sb.pop_front() : e_none;
        checks++;
        if ({commit_prd, commit_old_prd, commit_data} !== {e.prd, e.old_prd, e.data}) begin
          failures++;
          $display("FAIL wrap_payload c=%0d got=%h/%h/%h exp=%h/%h/%h", c, commit_prd,
                   commit_old_prd, commit_data, e.prd, e.old_prd, e.data);
        end
      end
      tick();
      if (c < 40) begin
        last_idx = m_tail;
        m_tail++;
      end
    end
    idle_inputs();
    #1;
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL wrap_empty got=%b exp=1", empty);
    end
  endtask

  task automatic test_flush();
    rob_idx_t h = m_tail;
    for (int i = 0; i < 5; i++) begin
      alloc_valid   = 1'b1;
      alloc_prd     = preg_t'(40 + i);
      alloc_old_prd = preg_t'(i);
      tick();
      m_tail++;
    end
    alloc_valid = 1'b0;
    wb_valid    = 1'b1;
    wb_index    = h + 1'b1;
    wb_data     = 32'h11;
    tick();
    wb_index = h;
    wb_data  = 32'h22;
    tick();
    wb_valid    = 1'b0;
    flush       = 1'b1;
    alloc_valid = 1'b1;
    #1;
    checks++;
    if ({commit_valid, alloc_ready} !== 2'b00) begin
      failures++;
      $display("FAIL flush_cycle got=%b/%b exp=0/0", commit_valid, alloc_ready);
    end
    tick();
    idle_inputs();
    sb.delete();
    m_tail = '0;
    #1;
    checks++;
    if ({empty, rob_index, commit_valid} !== {1'b1, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL flush_after got=%b/%0d/%b exp=1/0/0", empty, rob_index, commit_valid);
    end
    wb_valid = 1'b1;
    wb_index = h;
    wb_data  = 32'hDEAD;
    tick();
    wb_index = 4'd0;
    tick();
    wb_valid = 1'b0;
    #1;
    checks++;
    if ({empty, rob_index, commit_valid} !== {1'b1, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL flush_stale_wb got=%b/%0d/%b exp=1/0/0", empty, rob_index, commit_valid);
    end
  endtask

  task automatic test_same_cycle();
    for (int i = 0; i < 8; i++) begin
      alloc_valid   = 1'b1;
      alloc_prd     = preg_t'(i + 8);
      alloc_old_prd = preg_t'(63 - i);
      sb_push(m_tail, alloc_prd, alloc_old_prd);
      tick();
      m_tail++;
    end
    alloc_valid = 1'b0;
    wb_valid    = 1'b1;
    wb_index    = 4'd0;
    wb_data     = 32'hCAFE;
    sb_wb(4'd0, wb_data);
    tick();
    wb_valid      = 1'b0;
    alloc_valid   = 1'b1;
    alloc_prd     = 6'd33;
    alloc_old_prd = 6'd34;
    #1;
    e = (sb.size() != 0) ? sb.pop_front() : e_none;
    checks++;
    if ({commit_valid, alloc_ready, rob_index, commit_prd, commit_data} !==
        {2'b11, m_tail, e.prd, e.data}) begin
      failures++;
      $display("FAIL same_cycle got=%b/%b/%0d/%h/%h exp=1/1/%0d/%h/%h", commit_valid,
               alloc_ready, rob_index, commit_prd, commit_data, m_tail, e.prd, e.data);
    end
    sb_push(m_tail, alloc_prd, alloc_old_prd);
    tick();
    m_tail++;
    alloc_valid = 1'b0;
    wb_valid    = 1'b1;
    wb_index    = 4'd12;
    wb_data     = 32'hBAD;
    tick();
    wb_valid = 1'b0;
    #1;
    checks++;
    if ({commit_valid, rob_index, empty} !== {1'b0, m_tail, 1'b0}) begin
      failures++;
      $display("FAIL invalid_wb got=%b/%0d/%b exp=0/%0d/0", commit_valid, rob_index, empty,
               m_tail);
    end
    // Eight more allocs must fit exactly if the count stayed at eight.
    for (int i = 0; i < 8; i++) begin
      alloc_valid   = 1'b1;
      alloc_prd     = preg_t'(i + 16);
      alloc_old_prd = preg_t'(i + 24);
      #1;
      checks++;
      if (alloc_ready !== 1'b1) begin
        failures++;
        $display("FAIL same_refill i=%0d got=%b exp=1", i, alloc_ready);
      end
      sb_push(m_tail, alloc_prd, alloc_old_prd);
      tick();
      m_tail++;
    end
    #1;
    checks++;
    if (alloc_ready !== 1'b0) begin
      failures++;
      $display("FAIL same_full got=%b exp=0", alloc_ready);
    end
    alloc_valid = 1'b0;
    drain_full("same_drain");
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_wrap();
    test_flush();
    test_same_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
